// File: rtl/conv_share_ctrl.sv
// Round-robin sequencer sharing one registered 4-bit conversion datapath between two requesters.
// Optional macro CONV_SAT_CHECK_EN adds res_ovf and saturates unrepresentable negations to -8.
module conv_share_ctrl #(
  parameter int unsigned CONV_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic [1:0] mode,
  output logic [1:0] ack,
  output logic [3:0] res_data,
  output logic       res_valid,
`ifdef CONV_SAT_CHECK_EN
  output logic       res_ovf,
`endif
  output logic [3:0] conv_in,
  output logic       conv_mode,
  output logic       conv_en,
  input  logic [3:0] conv_out
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic          id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] conv_in_q, conv_in_d;
  logic          conv_mode_q, conv_mode_d;
  logic          conv_en_q, conv_en_d;
  logic          win;
`ifdef CONV_SAT_CHECK_EN
  logic          res_ovf_q, res_ovf_d;
`endif

  // Single requester wins outright; on contention the rr pointer decides.
  assign win = (req == 2'b11) ? rr_q : req[1];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    conv_in_d   = conv_in_q;
    conv_mode_d = conv_mode_q;
    conv_en_d   = 1'b0;
`ifdef CONV_SAT_CHECK_EN
    res_ovf_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          id_d        = win;
          conv_in_d   = win ? data1 : data0;
          conv_mode_d = mode[win];
          conv_en_d   = 1'b1;
          if (&req) rr_d = ~rr_q;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(CONV_LAT)) begin
          ack_d[id_q] = 1'b1;
          res_valid_d = 1'b1;
          res_data_d  = conv_out;
`ifdef CONV_SAT_CHECK_EN
          // -9..-15 do not fit in 4 bits; clamp to -8 and flag it.
          if (conv_mode_q && (conv_in_q > DW'(8))) begin
            res_ovf_d  = 1'b1;
            res_data_d = 4'b1000;
          end
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        cnt_d       = '0;
        conv_in_d   = '0;
        conv_mode_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      conv_in_q   <= '0;
      conv_mode_q <= 1'b0;
      conv_en_q   <= 1'b0;
`ifdef CONV_SAT_CHECK_EN
      res_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      conv_in_q   <= conv_in_d;
      conv_mode_q <= conv_mode_d;
      conv_en_q   <= conv_en_d;
`ifdef CONV_SAT_CHECK_EN
      res_ovf_q   <= res_ovf_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign conv_in   = conv_in_q;
  assign conv_mode = conv_mode_q;
  assign conv_en   = conv_en_q;
`ifdef CONV_SAT_CHECK_EN
  assign res_ovf   = res_ovf_q;
`endif

endmodule

// File: tb/tb_conv_share_ctrl.sv
// Scoreboard bench for conv_share_ctrl: transaction-level arbitration/result model plus a
// behavioural converter with CONV_LAT edges of latency.
module tb_conv_share_ctrl;

  localparam int unsigned LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] data0, data1;
  logic [1:0] mode;
  logic [1:0] ack;
  logic [3:0] res_data;
  logic       res_valid;
  logic       res_ovf;
  logic [3:0] conv_in;
  logic       conv_mode;
  logic       conv_en;
  logic [3:0] conv_out;

  conv_share_ctrl #(.CONV_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .mode(mode),
    .ack(ack), .res_data(res_data), .res_valid(res_valid),
`ifdef CONV_SAT_CHECK_EN
    .res_ovf(res_ovf),
`endif
    .conv_in(conv_in), .conv_mode(conv_mode), .conv_en(conv_en), .conv_out(conv_out)
  );
`ifndef CONV_SAT_CHECK_EN
  assign res_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter: result valid LAT edges after conv_en is sampled, garbage otherwise.
  logic [3:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= conv_en ? (conv_mode ? 4'(~conv_in + 4'd1) : conv_in) : 4'($urandom);
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign conv_out = pipe[LAT-1];

  typedef struct {
    logic [1:0]  ack;
    logic [3:0]  data;
    logic        ovf;
    int unsigned at;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   rr_m     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction-level reference: winner, result and ack cycle for a grant sampled at edge t0.
  task automatic predict(input logic [1:0] r, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [1:0] m, input int unsigned t0,
                         output logic [3:0] op, output logic mm);
    exp_t e;
    int   w;
    if (r == 2'b11) begin
      w    = int'(rr_m);
      rr_m = ~rr_m;
    end else begin
      w = (r == 2'b10) ? 1 : 0;
    end
    op    = (w == 1) ? d1 : d0;
    mm    = m[w];
    e.ack = (w == 1) ? 2'b10 : 2'b01;
    e.ovf = 1'b0;
    e.data = mm ? 4'((16 - int'(op)) % 16) : op;
`ifdef CONV_SAT_CHECK_EN
    if (mm && op > 4'd8) begin
      e.data = 4'd8;
      e.ovf  = 1'b1;
    end
`endif
    e.at = t0 + 1 + LAT;
    sbq.push_back(e);
  endtask

  // Monitor: every ack/res_valid must match the head of the scoreboard on its predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    if (ack != 2'b00 || res_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", {29'd0, res_valid, ack}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("ack", ack, e.ack);
        check("res_valid", res_valid, 1);
        check("res_data", res_data, e.data);
        check("res_ovf", res_ovf, e.ovf);
        check("ack_cycle", cyc, e.at);
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].at) begin
      e = sbq.pop_front();
      check("ack_missing", ack, e.ack);
    end
  end

  task automatic drain();
    for (int i = 0; i < 4 * int'(LAT) + 20 && sbq.size() != 0; i++) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_ovf"}, res_ovf, 0);
    check({tag, "_conv_in"}, conv_in, 0);
    check({tag, "_conv_mode"}, conv_mode, 0);
    check({tag, "_conv_en"}, conv_en, 0);
  endtask

  // One granted transaction; req is dropped right after the grant and inputs scrambled.
  task automatic do_txn(input logic [1:0] r, input logic [3:0] d0, input logic [3:0] d1,
                        input logic [1:0] m);
    logic [3:0]  op;
    logic        mm;
    int unsigned t0;
    @(negedge clk);
    req = r; data0 = d0; data1 = d1; mode = m;
    t0 = cyc + 1;
    predict(r, d0, d1, m, t0, op, mm);
    @(negedge clk);
    check("conv_en_pulse", conv_en, 1);
    check("conv_in", conv_in, op);
    check("conv_mode", conv_mode, mm);
    req = 2'b00; data0 = 4'($urandom); data1 = 4'($urandom); mode = 2'($urandom);
    @(negedge clk);
    check("conv_en_drop", conv_en, 0);
    drain();
  endtask

  initial begin
    logic [3:0]  op;
    logic        mm;
    int unsigned c, target;
    rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0; mode = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    rr_m = 1'b0;

    // Single requester, reinterpret.
    do_txn(2'b01, 4'b0011, 4'b0000, 2'b00);

    // Contention held continuously: requester 0 first, then alternation.
    @(negedge clk);
    req = 2'b11; data0 = 4'd2; data1 = 4'd5; mode = 2'b11;
    c = cyc;
    for (int k = 0; k < 3; k++) predict(2'b11, 4'd2, 4'd5, 2'b11, c + 1 + k * (LAT + 3), op, mm);
    target = c + 1 + 2 * (LAT + 3) + 1 + LAT;
    while (cyc < target) @(negedge clk);
    req = 2'b00;
    drain();

    // Requester 1 alone, full-scale operand.
    do_txn(2'b10, 4'b0000, 4'b1111, 2'b00);

    // Negation boundaries: 9 overflows with the check, 8 and 0 never do.
    do_txn(2'b01, 4'd9, 4'd0, 2'b01);
    do_txn(2'b01, 4'd8, 4'd0, 2'b01);
    do_txn(2'b10, 4'd3, 4'd0, 2'b10);
    do_txn(2'b10, 4'd3, 4'd15, 2'b10);

    // Reset mid-WAIT: no ack, outputs cleared, pointer back to requester 0.
    @(negedge clk);
    req = 2'b11; data0 = 4'd6; data1 = 4'd7; mode = 2'b00;
    @(negedge clk);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    rst = 1'b0;
    rr_m = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    do_txn(2'b11, 4'd4, 4'd10, 2'b00);
    do_txn(2'b11, 4'd4, 4'd10, 2'b11);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      do_txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    drain();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
